// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants for the RAM-backed FIFO controller and its 64x8 RAM.
package ram_fifo_ctrl_pkg;

  localparam int unsigned FIFO_DATA_W    = 8;
  localparam int unsigned FIFO_ADDR_W    = 6;
  localparam int unsigned FIFO_DEPTH     = 2 ** FIFO_ADDR_W;
  localparam int unsigned FIFO_AF_THRESH = 56;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Write and read valid/ready streams of the RAM FIFO; slave is the FIFO side.
interface ram_fifo_ctrl_if
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/ram_fifo_ctrl_ram.sv
// 64x8 RAM with separate read/write addresses and a registered read port.
module ram_fifo_ctrl_ram
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = FIFO_DATA_W,
  parameter int unsigned ADDR_W   = FIFO_ADDR_W,
  parameter bit          NEW_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem [2 ** ADDR_W];

  // NEW_DATA selects write-first behaviour on a same-address read/write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[write_addr] <= data_in;
    end
    if (NEW_DATA && we && (write_addr == read_addr)) begin
      data_out <= data_in;
    end else begin
      data_out <= mem[read_addr];
    end
  end

endmodule

// File: rtl/ram_fifo_top.sv
// FIFO controller wired to its 64x8 RAM; the complete 64-entry FIFO.
module ram_fifo_top
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = FIFO_DATA_W,
  parameter int unsigned ADDR_W    = FIFO_ADDR_W,
  parameter int unsigned AF_THRESH = FIFO_AF_THRESH,
  parameter bit          NEW_DATA  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  ram_fifo_ctrl_if.slave  stream,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            empty,
  output logic            almost_full
);

  logic              ram_we;
  logic [ADDR_W-1:0] ram_write_addr;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  ram_fifo_ctrl #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .AF_THRESH (AF_THRESH)
  ) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .stream         (stream),
    .ram_we         (ram_we),
    .ram_write_addr (ram_write_addr),
    .ram_read_addr  (ram_read_addr),
    .ram_data_in    (ram_data_in),
    .ram_data_out   (ram_data_out),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .almost_full    (almost_full)
  );

  ram_fifo_ctrl_ram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NEW_DATA (NEW_DATA)
  ) u_ram (
    .clk        (clk),
    .we         (ram_we),
    .write_addr (ram_write_addr),
    .read_addr  (ram_read_addr),
    .data_in    (ram_data_in),
    .data_out   (ram_data_out)
  );

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that turns a 1-cycle-latency RAM into a valid/ready FIFO with
// occupancy, almost-full and synchronous flush.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = FIFO_DATA_W,
  parameter int unsigned ADDR_W    = FIFO_ADDR_W,
  parameter int unsigned AF_THRESH = FIFO_AF_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  ram_fifo_ctrl_if.slave    stream,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [ADDR_W-1:0] ram_read_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full
);

  localparam int unsigned   DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AfCnt    = (ADDR_W + 1)'(AF_THRESH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_inc;
  logic [ADDR_W:0]   count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready;
  logic              push, pop;

  assign full        = (count_q == DepthCnt);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AfCnt);
  assign in_ready    = !full && !flush;

  assign push       = stream.in_valid && in_ready;
  assign pop        = out_valid_q && stream.out_ready;
  assign rd_ptr_inc = rd_ptr_q + ADDR_W'(1);

  assign ram_we         = push;
  assign ram_write_addr = wr_ptr_q;
  assign ram_data_in    = stream.in_data;
  // Look ahead on pop so the registered RAM output already holds the new head.
  assign ram_read_addr  = pop ? rd_ptr_inc : rd_ptr_q;

  assign stream.in_ready  = in_ready;
  assign stream.out_data  = ram_data_out;
  assign stream.out_valid = out_valid_q;
  assign count            = count_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_inc;
      end
      count_d     = count_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
      // Pre-push count: a word written this edge is not yet readable.
      out_valid_d = (count_q - (ADDR_W + 1)'(pop)) != '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- FIFO controller that sits directly upstream of the 64x8 single-port RAM with separate read/write addresses and a registered data_out.
- Accepts a valid/ready write stream and generates the RAM's we, write_addr and read_addr.
- Presents the RAM's data_out as a valid/ready read stream.
- Turns the bare RAM into a 64-entry FIFO with full/empty, occupancy, almost-full and flush.

Parameters:
DATA_W, 8, data width; must match the RAM word width
ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W = 64
AF_THRESH, 56, almost_full asserts when count >= AF_THRESH

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of FIFO state
in_data  in  DATA_W  write-stream data
in_valid  in  1  write-stream valid
in_ready  out  1  write-stream ready
out_data  out  DATA_W  read-stream data, wired from ram_data_out
out_valid  out  1  read-stream valid
out_ready  in  1  read-stream ready
ram_we  out  1  to RAM we
ram_write_addr  out  ADDR_W  to RAM write_addr
ram_read_addr  out  ADDR_W  to RAM read_addr
ram_data_in  out  DATA_W  to RAM data_in, equal to in_data
ram_data_out  in  DATA_W  from RAM data_out, 1-cycle registered read
count  out  ADDR_W+1  stored entries, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, out_valid=0. Outputs follow immediately without a clock: empty=1, full=0, almost_full=0, in_ready=1.
- RAM contents are not cleared by rst or flush.
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !full & !flush. A full FIFO never accepts in the same cycle as a pop; there is no pass-through.
- Write path:
  - ram_we = push, ram_write_addr = wr_ptr.
  - On push, wr_ptr <= wr_ptr+1, wrapping modulo DEPTH (63 -> 0).
- Read path (combinational address):
  - ram_read_addr = pop ? rd_ptr+1 : rd_ptr, modulo DEPTH.
  - On pop, rd_ptr <= rd_ptr+1.
  - The RAM returns ram[ram_read_addr] after the edge, so out_data always reflects the current head.
- out_valid register: next = ((count - pop) > 0), evaluated with pre-push count.
  - This asserts valid only when the address being read held data written at an earlier edge.
- count <= count + push - pop. A simultaneous push and pop leaves count unchanged.
- Latency: a push accepted in cycle c into an empty FIFO gives out_valid=1 in cycle c+2. With count >= 2, throughput is one pop per cycle.
- Read/write collision: ram_read_addr == ram_write_addr with ram_we=1 occurs only when count - pop == 0. out_valid is then 0 next cycle, so the collided read value is discarded. Correctness holds for either RAM read-during-write semantics (old or new data).
- Steady push+pop at count=1: one out_valid bubble, then count settles at 2 and streams 1/cycle.
- out_data is only meaningful while out_valid=1. Holding out_ready=0 keeps rd_ptr and therefore out_data stable.
- flush has priority over push and pop. At the next edge wr_ptr=rd_ptr=0, count=0, out_valid=0. Data offered during flush is dropped because in_ready=0.
- rst asserted mid-operation: state clears asynchronously. Any stream in flight is lost and no error is flagged.
- No overflow/underflow is possible by construction, since in_ready and out_valid gate all transfers.

Decomposition:
- Shared package/header holds the constants: DATA_W=8, ADDR_W=6, DEPTH=64, default AF_THRESH.
- One natural sub-module: ram_fifo_top, which instantiates ram_fifo_ctrl plus the 64x8 RAM. Verification runs against this top.
- The pointer/count logic stays inline in ram_fifo_ctrl.

Test Plan:
- Reset: pulse rst with no clock edge -> out_valid=0, count=0, empty=1, in_ready=1 immediately.
- Single push of 0xA5 in cycle c, out_ready=0 -> count=1 from c+1; out_valid=1 and out_data=0xA5 from c+2, held until out_ready=1; then empty=1.
- Fill with 0x00..0x3F -> almost_full rises at count=56, full=1 and in_ready=0 at count=64; a 65th offer is not accepted. Drain with out_ready=1 -> 0x00..0x3F in order, one per cycle after the first.
- Push and pop every cycle starting from count=1 -> exactly one out_valid bubble, then count=2 steady. No value lost or duplicated, including under both RAM read-during-write models.
- 300 items with random in_valid/out_ready stalls -> output sequence equals input sequence; pointers wrap 63->0 at least four times; count never exceeds 64.
- With count=10: assert flush for one cycle while in_valid=1 -> count=0, out_valid=0 next cycle and the offered word is dropped. Then refill, and assert rst between edges -> state clears asynchronously.
